// File: rtl/math_subtractor_brent_kung_pipe_008.sv
// Two-stage pipelined N-bit subtractor: diff = a - b - bin (mod 2^N).
// The subtraction is done as a + ~b + ~bin. Stage 1 registers the bitwise
// propagate/generate terms. Stage 2 resolves the carries with a Brent-Kung
// prefix tree, which treats the carry-in as bit -1. It then registers diff,
// the unsigned borrow-out and the signed overflow flag.
// Each stage has a valid flag and advances when it is empty or when the
// stage after it advances.
// Optional feature: define MATH_SUB_BK_ZERO_FLAG_EN to add the registered
// o_zero output.
module math_subtractor_brent_kung_pipe_008 #(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_bin,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_diff,
   output logic         o_bout,
`ifdef MATH_SUB_BK_ZERO_FLAG_EN
   output logic         o_zero,
`endif
   output logic         o_ovf
);

   // Prefix positions: 0 holds the carry-in, 1..N hold operand bits 0..N-1.
   localparam int M = N + 1;

   // Largest power-of-two span that is smaller than the number of positions.
   function automatic int top_step(input int m);
      int d;
      d = 1;
      while (d * 2 < m) begin
         d = d * 2;
      end
      return d;
   endfunction

   localparam int TOP_D = top_step(M);

   // Black cell: merges two groups into one group {generate, propagate}.
   function automatic logic [1:0] black_cell(input logic gh, input logic ph,
                                             input logic gl, input logic pl);
      return {gh | (ph & gl), ph & pl};
   endfunction

   // Gray cell: merges with a lower group that already includes the carry-in.
   function automatic logic gray_cell(input logic gh, input logic ph, input logic gl);
      return gh | (ph & gl);
   endfunction

   logic         s1_valid_r;
   logic [N-1:0] s1_p_r;
   logic [N-1:0] s1_g_r;
   logic         s1_cin_r;
   logic         s1_a_msb_r;
   logic         s1_b_msb_r;

   logic         s1_adv_s;
   logic         s2_adv_s;
   logic         in_xfer_s;
   logic [M-1:0] carry_s;
   logic [N-1:0] diff_s;
   logic         ovf_s;

   // Handshake: a stage may load when it is empty or when its contents move on.
   always_comb begin
      s2_adv_s  = ~o_valid | i_ready;
      s1_adv_s  = ~s1_valid_r | s2_adv_s;
      o_ready   = s1_adv_s;
      in_xfer_s = i_valid & s1_adv_s;
   end

   // Brent-Kung prefix tree: up-sweep builds power-of-two spans, down-sweep fills the gaps.
   always_comb begin
      logic [M-1:0] g_v;
      logic [M-1:0] p_v;
      logic [M-1:0] z_v;
      g_v = {s1_g_r, s1_cin_r};
      p_v = {s1_p_r, 1'b0};
      z_v = {{N{1'b0}}, 1'b1};
      for (int d = 1; d < M; d = d * 2) begin
         for (int i = 2 * d - 1; i < M; i = i + 2 * d) begin
            if (z_v[i-d]) begin
               g_v[i] = gray_cell(g_v[i], p_v[i], g_v[i-d]);
               p_v[i] = 1'b0;
               z_v[i] = 1'b1;
            end else begin
               {g_v[i], p_v[i]} = black_cell(g_v[i], p_v[i], g_v[i-d], p_v[i-d]);
               z_v[i] = 1'b0;
            end
         end
      end
      for (int d = TOP_D; d >= 1; d = d / 2) begin
         for (int i = 3 * d - 1; i < M; i = i + 2 * d) begin
            g_v[i] = gray_cell(g_v[i], p_v[i], g_v[i-d]);
            p_v[i] = 1'b0;
            z_v[i] = 1'b1;
         end
      end
      carry_s = g_v;
   end

   // Sum bits and signed overflow are formed from the resolved carries.
   always_comb begin
      diff_s = s1_p_r ^ carry_s[N-1:0];
      ovf_s  = (s1_a_msb_r != s1_b_msb_r) & (diff_s[N-1] != s1_a_msb_r);
   end

   // Stage 1: capture propagate/generate, carry-in and operand sign bits on a transfer.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_r <= 1'b0;
         s1_p_r     <= {N{1'b0}};
         s1_g_r     <= {N{1'b0}};
         s1_cin_r   <= 1'b0;
         s1_a_msb_r <= 1'b0;
         s1_b_msb_r <= 1'b0;
      end else begin
         if (s1_adv_s) begin
            s1_valid_r <= i_valid;
         end
         if (in_xfer_s) begin
            s1_p_r     <= i_a ^ ~i_b;
            s1_g_r     <= i_a & ~i_b;
            s1_cin_r   <= ~i_bin;
            s1_a_msb_r <= i_a[N-1];
            s1_b_msb_r <= i_b[N-1];
         end
      end
   end

   // Stage 2: register the result; hold everything while downstream stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_diff  <= {N{1'b0}};
         o_bout  <= 1'b0;
         o_ovf   <= 1'b0;
`ifdef MATH_SUB_BK_ZERO_FLAG_EN
         o_zero  <= 1'b0;
`endif
      end else if (s2_adv_s) begin
         o_valid <= s1_valid_r;
         if (s1_valid_r) begin
            o_diff <= diff_s;
            o_bout <= ~carry_s[N];
            o_ovf  <= ovf_s;
`ifdef MATH_SUB_BK_ZERO_FLAG_EN
            o_zero <= (diff_s == {N{1'b0}});
`endif
         end
      end
   end

endmodule

// File: tb/tb_math_subtractor_brent_kung_pipe_008.sv
// Self-checking bench for math_subtractor_brent_kung_pipe_008 (N = 8).
// It uses a vector table, directed stall and reset sequences, and random
// traffic checked by a scoreboard against an arithmetic reference.
module tb_math_subtractor_brent_kung_pipe_008;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] i_a;
   logic [7:0] i_b;
   logic       i_bin;
   logic       o_valid;
   logic       i_ready;
   logic [7:0] o_diff;
   logic       o_bout;
   logic       o_ovf;
`ifdef MATH_SUB_BK_ZERO_FLAG_EN
   logic       o_zero;
`endif

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];

   math_subtractor_brent_kung_pipe_008 #(.N(8)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_a     (i_a),
      .i_b     (i_b),
      .i_bin   (i_bin),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_diff  (o_diff),
      .o_bout  (o_bout),
`ifdef MATH_SUB_BK_ZERO_FLAG_EN
      .o_zero  (o_zero),
`endif
      .o_ovf   (o_ovf)
   );

   always #5 i_clk = ~i_clk;

   // Reference: {diff, borrow-out, signed overflow} computed with plain integer arithmetic.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int ua;
      int ub;
      int sa;
      int sb;
      int ur;
      int sr;
      logic [7:0] d;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      ur = ua - ub - int'(bin);
      sr = sa - sb - int'(bin);
      d  = 8'((ur + 256) % 256);
      return {d, (ur < 0), (sr < -128 || sr > 127)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
      i_valid = v;
      i_a     = a;
      i_b     = b;
      i_bin   = bin;
   endtask

   // Scoreboard: transfers are decided by signals that are stable between negedge and the next posedge.
   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         exp_q.delete();
      end else begin
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_result", 32'(o_valid), 32'd0);
            end else begin
               check("sb_result", {22'd0, o_diff, o_bout, o_ovf}, {22'd0, exp_q.pop_front()});
            end
         end
         if (i_valid && o_ready) begin
            exp_q.push_back(model(i_a, i_b, i_bin));
         end
      end
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [9:0] e;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbin;

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[3] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[5] = '{8'h42, 8'h41, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

      // Reset state
      i_rst_n = 1'b0;
      i_ready = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      #1;
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_o_ready", 32'(o_ready), 32'd1);
      check("rst_outputs", {22'd0, o_diff, o_bout, o_ovf}, 32'd0);
      tick();
      tick();
      #1;
      i_rst_n = 1'b1;

      // Table vectors: single transfers, exact 2-cycle latency
      for (int k = 0; k < 8; k++) begin
         tick();
         drive(1'b1, vecs[k].a, vecs[k].b, vecs[k].bin);
         tick();
         drive(1'b0, 8'h00, 8'h00, 1'b0);
         check("vec_not_early", 32'(o_valid), 32'd0);
         tick();
         check("vec_valid_at_2", 32'(o_valid), 32'd1);
         check("vec_result", {22'd0, o_diff, o_bout, o_ovf},
               {22'd0, vecs[k].diff, vecs[k].bout, vecs[k].ovf});
`ifdef MATH_SUB_BK_ZERO_FLAG_EN
         check("vec_zero", 32'(o_zero), 32'(vecs[k].diff == 8'h00));
`endif
      end
      tick();

      // Stall: three operations while the output is blocked for four cycles
      i_ready = 1'b0;
      drive(1'b1, 8'd10, 8'd1, 1'b0);
      #1;
      check("stall_ready_c0", 32'(o_ready), 32'd1);
      tick();
      drive(1'b1, 8'd20, 8'd2, 1'b0);
      #1;
      check("stall_ready_c1", 32'(o_ready), 32'd1);
      tick();
      drive(1'b1, 8'd30, 8'd3, 1'b0);
      #1;
      check("stall_ready_full", 32'(o_ready), 32'd0);
      check("stall_diff_c2", {24'd0, o_diff}, 32'd9);
      check("stall_valid_c2", 32'(o_valid), 32'd1);
      tick();
      #1;
      check("stall_ready_held", 32'(o_ready), 32'd0);
      check("stall_diff_held", {24'd0, o_diff}, 32'd9);
      tick();
      i_ready = 1'b1;
      #1;
      check("stall_diff_c4", {24'd0, o_diff}, 32'd9);
      check("stall_ready_release", 32'(o_ready), 32'd1);
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      check("stall_diff_c5", {24'd0, o_diff}, 32'd18);
      check("stall_valid_c5", 32'(o_valid), 32'd1);
      tick();
      check("stall_diff_c6", {24'd0, o_diff}, 32'd27);
      check("stall_valid_c6", 32'(o_valid), 32'd1);
      tick();
      check("stall_drained", 32'(o_valid), 32'd0);

      // Back-to-back stream of 16 random operations
      for (int k = 0; k < 20; k++) begin
         tick();
         if (k < 16) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
         end else begin
            drive(1'b0, 8'h00, 8'h00, 1'b0);
         end
         if (k >= 2 && k < 18) begin
            check("stream_valid", 32'(o_valid), 32'd1);
         end else begin
            check("stream_idle", 32'(o_valid), 32'd0);
         end
      end

      // Reset with two results in flight
      tick();
      drive(1'b1, 8'h33, 8'h11, 1'b0);
      tick();
      drive(1'b1, 8'h44, 8'h22, 1'b1);
      tick();
      i_rst_n = 1'b0;
      drive(1'b1, 8'h99, 8'h01, 1'b0);
      #1;
      check("mid_rst_valid", 32'(o_valid), 32'd0);
      check("mid_rst_outputs", {22'd0, o_diff, o_bout, o_ovf}, 32'd0);
      check("mid_rst_ready", 32'(o_ready), 32'd1);
      tick();
      check("mid_rst_discard", 32'(o_valid), 32'd0);
      #1;
      i_rst_n = 1'b1;
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("post_rst_no_ghost", 32'(o_valid), 32'd0);
      end
      ra = 8'hC3;
      rb = 8'h3C;
      e = model(ra, rb, 1'b1);
      drive(1'b1, ra, rb, 1'b1);
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      check("post_rst_not_early", 32'(o_valid), 32'd0);
      tick();
      check("post_rst_valid", 32'(o_valid), 32'd1);
      check("post_rst_result", {22'd0, o_diff, o_bout, o_ovf}, {22'd0, e});

      // Random traffic with random backpressure
      for (int k = 0; k < 400; k++) begin
         tick();
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rbin = 1'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            rb = ra;
         end
         drive(1'($urandom), ra, rb, rbin);
         i_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      drive(1'b0, 8'h00, 8'h00, 1'b0);
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_idle", 32'(o_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
